// File: rtl/pipe_skid.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// Optional synchronous flush port is enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    // Handshake: a word moves on a port only in a cycle where its valid and
    // ready are both 1 at the rising edge; in_ready and out_valid are flops,
    // so neither depends combinationally on anything the other side drives.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] m;
    logic [N-1:0] m_next;
    logic [N-1:0] s;
    logic [N-1:0] s_next;
    logic         in_ready_q;
    logic         in_ready_next;
    logic         out_valid_q;
    logic         out_valid_next;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_next = state;
        m_next     = m;
        s_next     = s;

        case (state)
            EMPTY: begin
                if (in_fire) begin
                    m_next     = in_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_next = in_data;
                end else if (in_fire) begin
                    s_next     = in_data;
                    state_next = TWO;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    m_next     = s;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

`ifdef PIPE_SKID_FLUSH_EN
        // Flush drops every held word but leaves the data registers untouched.
        if (flush) begin
            state_next = EMPTY;
            m_next     = m;
            s_next     = s;
        end
`endif

        in_ready_next  = (state_next != TWO);
        out_valid_next = (state_next != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            m           <= '0;
            s           <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            m           <= m_next;
            s           <= s_next;
            in_ready_q  <= in_ready_next;
            out_valid_q <= out_valid_next;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m;

endmodule

// File: tb/tb_pipe_skid.sv
// Directed vector bench for pipe_skid; flush checks are built when PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;
    logic         flush;

    int n_vec;
    int n_bad;

    pipe_skid #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [N-1:0] d;
        logic         ordy;
        logic         e_ov;
        logic [N-1:0] e_od;
        logic         e_ir;
    } vec_t;

    vec_t vecs[$];
    logic [N-1:0] exp_q[$];

    task automatic add(input logic rst, input logic iv, input logic [N-1:0] d,
                       input logic ordy, input logic e_ov, input logic [N-1:0] e_od,
                       input logic e_ir);
        vec_t v;
        v.rst = rst; v.fl = 1'b0; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic e_ov, input logic [N-1:0] e_od,
                         input logic e_ir);
        n_vec++;
        if (out_valid !== e_ov) begin
            n_bad++;
            $display("FAIL %s out_valid got %0b want %0b", name, out_valid, e_ov);
        end
        if (out_data !== e_od) begin
            n_bad++;
            $display("FAIL %s out_data got %0d want %0d", name, out_data, e_od);
        end
        if (in_ready !== e_ir) begin
            n_bad++;
            $display("FAIL %s in_ready got %0b want %0b", name, in_ready, e_ir);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample just after the edge.
    task automatic cyc(input logic rst, input logic fl, input logic iv,
                       input logic [N-1:0] d, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset with a word offered, then first word after release
        add(1, 1, 5, 0, 0, 0, 1);
        add(1, 1, 5, 0, 0, 0, 1);
        add(0, 1, 6, 0, 1, 6, 1);
        add(0, 0, 99, 1, 0, 6, 1);
        // streaming 1..9 with the consumer always ready
        for (int k = 1; k <= 9; k++) add(0, 1, k, 1, 1, k, 1);
        add(0, 0, 99, 1, 0, 9, 1);
        // backpressure: 10,11 accepted, 12 held off until space frees
        add(0, 1, 10, 0, 1, 10, 1);
        add(0, 1, 11, 0, 1, 10, 0);
        add(0, 1, 12, 0, 1, 10, 0);
        add(0, 1, 12, 1, 1, 11, 1);
        add(0, 1, 12, 1, 1, 12, 1);
        add(0, 0, 99, 1, 0, 12, 1);
        // simultaneous in/out in ONE, then idle hold
        add(0, 1, 20, 0, 1, 20, 1);
        add(0, 1, 21, 1, 1, 21, 1);
        add(0, 0, 99, 0, 1, 21, 1);
        // reset while holding two words; 32 must come out alone
        add(0, 1, 30, 1, 1, 30, 1);
        add(0, 1, 31, 0, 1, 30, 0);
        add(1, 0, 99, 0, 0, 0, 1);
        add(0, 1, 32, 0, 1, 32, 1);
        add(0, 0, 99, 1, 0, 32, 1);
        add(0, 0, 77, 1, 0, 32, 1);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir);
        end

`ifdef PIPE_SKID_FLUSH_EN
        // flush in TWO while offering 40: 40 is dropped, data regs keep 38
        cyc(0, 0, 1, 38, 0);
        cyc(0, 0, 1, 39, 0);
        check("flush_fill", 1, 38, 0);
        cyc(0, 1, 1, 40, 0);
        check("flush_two", 0, 38, 1);
        cyc(0, 0, 0, 99, 1);
        check("flush_after", 0, 38, 1);
        // flush with an output transfer in ONE
        cyc(0, 0, 1, 41, 0);
        check("flush_refill", 1, 41, 1);
        cyc(0, 1, 0, 99, 1);
        check("flush_one", 0, 41, 1);
`endif

        // ordering under a fixed stall pattern, checked against a scoreboard
        begin
            logic [15:0] stall_pat;
            logic [N-1:0] nxt;
            int cycles;
            stall_pat = 16'b1011_0010_0110_1100;
            nxt = 100;
            cycles = 0;
            while ((nxt < 112 || exp_q.size() != 0) && cycles < 200) begin
                logic iv;
                logic ordy;
                iv = (nxt < 112);
                ordy = stall_pat[cycles % 16];
                if (out_valid && ordy) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL order extra word got %0d want none", out_data);
                    end else begin
                        logic [N-1:0] e;
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            n_bad++;
                            $display("FAIL order got %0d want %0d", out_data, e);
                        end
                    end
                end
                if (iv && in_ready) begin
                    exp_q.push_back(nxt);
                end
                cyc(0, 0, iv, nxt, ordy);
                if (iv && exp_q.size() != 0 && exp_q[$] == nxt) nxt++;
                cycles++;
            end
            n_vec++;
            if (cycles >= 200 || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL order_drain left %0d words want 0 (cycles %0d)", exp_q.size(), cycles);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
